// File: rtl/hsv_to_rgb.sv
// rtl/hsv_to_rgb.sv - three-stage HSV-to-RGB converter with clock-enable stall
module hsv_to_rgb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        in_valid,
    input  logic [12:0] hue,
    input  logic [9:0]  sat,
    input  logic [9:0]  val,
    output logic        out_valid,
    output logic [9:0]  red,
    output logic [9:0]  green,
    output logic [9:0]  blue,
    output logic        range_err
);

    logic        s1_valid_q;
    logic [9:0]  s1_val_q;
    logic [2:0]  s1_sec_q;
    logic [9:0]  s1_f_q;
    logic        s1_oor_q;
    logic [9:0]  s1_vs_q;
    logic [9:0]  s1_vs_d;

    logic        s2_valid_q;
    logic [9:0]  s2_val_q;
    logic [2:0]  s2_sec_q;
    logic        s2_oor_q;
    logic [9:0]  s2_p_q;
    logic [19:0] s2_vsf_q;
    logic [20:0] s2_vsnf_q;
    logic [10:0] s2_nf;
    logic [9:0]  s2_p_d;
    logic [19:0] s2_vsf_d;
    logic [20:0] s2_vsnf_d;

    logic        out_valid_q;
    logic [9:0]  red_q;
    logic [9:0]  green_q;
    logic [9:0]  blue_q;
    logic        range_err_q;
    logic [9:0]  s3_q_d;
    logic [9:0]  s3_t_d;
    logic [9:0]  red_d;
    logic [9:0]  green_d;
    logic [9:0]  blue_d;

    assign s1_vs_d   = 10'((20'(val) * 20'(sat)) >> 10);

    // vs never exceeds val, so these subtractions cannot wrap
    assign s2_nf     = 11'd1024 - {1'b0, s1_f_q};
    assign s2_p_d    = s1_val_q - s1_vs_q;
    assign s2_vsf_d  = 20'(s1_vs_q) * 20'(s1_f_q);
    assign s2_vsnf_d = 21'(s1_vs_q) * 21'(s2_nf);

    assign s3_q_d    = s2_val_q - 10'(s2_vsf_q >> 10);
    assign s3_t_d    = s2_val_q - 10'(s2_vsnf_q >> 10);

    always_comb begin
        red_d   = s2_val_q;
        green_d = s2_val_q;
        blue_d  = s2_val_q;
        case (s2_sec_q)
            3'd0: begin red_d = s2_val_q; green_d = s3_t_d;   blue_d = s2_p_q;   end
            3'd1: begin red_d = s3_q_d;   green_d = s2_val_q; blue_d = s2_p_q;   end
            3'd2: begin red_d = s2_p_q;   green_d = s2_val_q; blue_d = s3_t_d;   end
            3'd3: begin red_d = s2_p_q;   green_d = s3_q_d;   blue_d = s2_val_q; end
            3'd4: begin red_d = s3_t_d;   green_d = s2_p_q;   blue_d = s2_val_q; end
            3'd5: begin red_d = s2_val_q; green_d = s2_p_q;   blue_d = s3_q_d;   end
            default: begin red_d = s2_val_q; green_d = s2_val_q; blue_d = s2_val_q; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_val_q    <= '0;
            s1_sec_q    <= '0;
            s1_f_q      <= '0;
            s1_oor_q    <= 1'b0;
            s1_vs_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_val_q    <= '0;
            s2_sec_q    <= '0;
            s2_oor_q    <= 1'b0;
            s2_p_q      <= '0;
            s2_vsf_q    <= '0;
            s2_vsnf_q   <= '0;
            out_valid_q <= 1'b0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            range_err_q <= 1'b0;
        end else if (ce) begin
            s1_valid_q  <= in_valid;
            s1_val_q    <= val;
            s1_sec_q    <= hue[12:10];
            s1_f_q      <= hue[9:0];
            s1_oor_q    <= (hue[12:11] == 2'b11);
            s1_vs_q     <= s1_vs_d;
            s2_valid_q  <= s1_valid_q;
            s2_val_q    <= s1_val_q;
            s2_sec_q    <= s1_sec_q;
            s2_oor_q    <= s1_oor_q;
            s2_p_q      <= s2_p_d;
            s2_vsf_q    <= s2_vsf_d;
            s2_vsnf_q   <= s2_vsnf_d;
            out_valid_q <= s2_valid_q;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            range_err_q <= s2_oor_q;
        end
    end

    assign out_valid = out_valid_q;
    assign red       = red_q;
    assign green     = green_q;
    assign blue      = blue_q;
    assign range_err = range_err_q;

endmodule

// File: doc/hsv_to_rgb.md
# hsv_to_rgb

Pipelined HSV-to-RGB converter for the neuro_skin pixel path. It is the inverse of the RGB-to-HSV front end: it takes the sector-encoded hue, saturation and value that the front end produces and reconstructs 10-bit R/G/B. It is used to render classifier overlays and to loop-back-check the forward converter. It is a three-stage pipeline with clock-enable stall and a valid flag.

## Interface
- No parameters. Channel width is fixed at 10 bits and hue width at 13 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  pipeline advance enable; when 0 the whole block freezes
- in_valid  in  1  hue/sat/val are valid this cycle (sampled only when ce=1)
- hue  in  13  hue[12:10] = sector 0..5, hue[9:0] = fraction f (f/1024 of a sector); legal range 0..6143
- sat  in  10  saturation, s/1024
- val  in  10  value (max channel)
- out_valid  out  1  red/green/blue/range_err valid
- red, green, blue  out  10 each  reconstructed channels
- range_err  out  1  qualified by out_valid; 1 if hue ≥ 6144

## Operation
- Arithmetic is unsigned and truncating. No rounding is applied.
- vs = (val*sat)>>10, 10 bits. By construction vs ≤ val, so no underflow occurs below.
- p = val − vs.
- q = val − ((vs*f)>>10).
- t = val − ((vs*(1024−f))>>10), where (1024−f) is 11 bits.
- Sector select gives (R,G,B):
  - 0 → (v,t,p)
  - 1 → (q,v,p)
  - 2 → (p,v,t)
  - 3 → (p,q,v)
  - 4 → (t,p,v)
  - 5 → (v,p,q)
- Sector 6 or 7 (out of range) → (v,v,v) with range_err=1. Otherwise range_err=0.
- Pipeline stages, each register loads only when ce=1:
  - S1 registers val, the sector, f and an out-of-range flag, and computes vs.
  - S2 registers p, vs*f and vs*(1024−f).
  - S3 registers q and t, performs the sector mux, and drives the outputs.
- A valid bit travels with each stage. Data registers may load on invalid slots; outputs are only meaningful when out_valid=1.
- There is no backpressure other than ce. The block accepts one sample per ce-enabled cycle.

## Timing
- Latency is 3 ce-enabled clock edges. A sample taken at edge N (ce=1, in_valid=1) appears with out_valid=1 after edge N+2 and is visible during the cycle following the third enabled edge.
- If ce=0 on any edge, no stage moves. Outputs and out_valid hold their values, so out_valid may stay high across stall cycles. The consumer must itself qualify with ce.
- Full throughput: consecutive in_valid samples with ce held at 1 produce consecutive out_valid cycles, in order.
- Reset (rst_n=0, asynchronous) clears all valid bits and outputs immediately:
  - out_valid=0, red=green=blue=0, range_err=0.
  - Samples in flight are discarded; none emerge after release.
- Reset release: the first enabled edge after rst_n rises may capture input normally.
- in_valid=0 with ce=1 inserts a bubble, which appears as out_valid=0 three enabled edges later.

## Test plan
- Gray input: hue=2000, sat=0, val=500 → after 3 edges, (500,500,500), range_err=0.
- Saturated red: hue=0, sat=1023, val=1023 → vs=1022, output (1023,1,1).
- Mid sector 2: hue=2560 (sector 2, f=512), sat=512, val=800 → vs=400, output (400,800,600).
- Out of range: hue=6200, sat=700, val=321 → (321,321,321) with range_err=1. Then hue=6143 → range_err=0.
- Stall and stream: 4 samples on consecutive cycles with ce driven 1,1,0,0,1,1,1,1 → exactly 4 out_valid cycles, in input order, each with 3-enabled-edge latency, and outputs frozen during the ce=0 cycles.
- Reset mid-stream: 2 samples in flight, then pull rst_n low asynchronously between edges → out_valid and all outputs drop to 0 at once, and no out_valid occurs after release until a new sample is sent.
